// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single Avalon-MM master port.
// Data has priority, but a pending fetch never waits behind more than one data access.
module mips_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                stall,
  output logic                timeout_err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              terr_q, terr_d;
  logic              i_owed_q, i_owed_d;
  logic              done, abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      terr_q    <= 1'b0;
      i_owed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      terr_q    <= terr_d;
      i_owed_q  <= i_owed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    terr_d    = terr_q;
    i_owed_d  = i_owed_q;
    done      = ~avm_waitrequest;
    abort     = TO_EN && avm_waitrequest && (cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        if (!i_req) i_owed_d = 1'b0;
        // A held request is still high during its ack cycle; granting then would serve it twice.
        if (!i_ack_q && !d_ack_q) begin
          if (d_req && !(i_req && i_owed_q)) begin
            state_d  = BUS_D;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            be_d     = d_be;
            we_d     = d_we;
            rd_d     = ~d_we;
            wr_d     = d_we;
            cnt_d    = '0;
            i_owed_d = i_req;
          end else if (i_req) begin
            state_d  = BUS_I;
            addr_d   = i_addr;
            be_d     = '1;
            we_d     = 1'b0;
            rd_d     = 1'b1;
            wr_d     = 1'b0;
            cnt_d    = '0;
            i_owed_d = 1'b0;
          end
        end
      end
      BUS_I, BUS_D: begin
        if (avm_waitrequest) cnt_d = cnt_q + CNT_W'(1);
        if (done || abort) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (abort) terr_d = 1'b1;
          if (state_q == BUS_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = done ? avm_readdata : '1;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = done ? avm_readdata : '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign i_ack          = i_ack_q;
  assign d_ack          = d_ack_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign timeout_err    = terr_q;
  assign stall          = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of all address ports.
REQ-002 Parameter DATA_W, default 32 (multiple of 8): width of all data ports.
REQ-003 Parameter TIMEOUT, default 255: max waitrequest-stall cycles per bus access; 0 disables timeout.
REQ-004 Ports, in this order: clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 i_req  in  1  instruction fetch request; held until i_ack.
REQ-007 i_addr  in  ADDR_W  fetch address.
REQ-008 i_rdata  out  DATA_W  fetched word; valid while i_ack=1.
REQ-009 i_ack  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data access request; held until d_ack.
REQ-011 d_we  in  1  1=write, 0=read.
REQ-012 d_addr  in  ADDR_W;  d_wdata  in  DATA_W;  d_be  in  DATA_W/8  byte enables.
REQ-013 d_rdata  out  DATA_W  read word; valid while d_ack=1.
REQ-014 d_ack  out  1  one-cycle data completion pulse.
REQ-015 stall  out  1  CPU hold: (i_req & ~i_ack) | (d_req & ~d_ack).
REQ-016 timeout_err  out  1  sticky timeout flag.
REQ-017 avm_address  out  ADDR_W;  avm_read  out  1;  avm_write  out  1;  avm_writedata  out  DATA_W;  avm_byteenable  out  DATA_W/8.
REQ-018 avm_waitrequest  in  1;  avm_readdata  in  DATA_W  valid in cycle waitrequest=0 during a read.

Function
REQ-019 FSM states IDLE, BUS_I, BUS_D; avm_read/avm_write SHALL be registered outputs, high only in BUS_I/BUS_D.
REQ-020 IDLE, i_ack=0 and d_ack=0: d_req=1 -> BUS_D (data priority); else i_req=1 -> BUS_I; else stay.
REQ-021 IDLE with i_ack or d_ack high: no grant that cycle (prevents double service of a held request).
REQ-022 On grant, address/wdata/be/we SHALL be captured into registers; avm_* driven from these and held stable for the whole access regardless of requester changes.
REQ-023 BUS_I: avm_read=1, avm_write=0, avm_byteenable all ones.
REQ-024 BUS_D: avm_read=~we, avm_write=we, avm_byteenable=captured d_be.
REQ-025 Completion = cycle in BUS_x with avm_waitrequest=0; next edge -> IDLE, x_ack=1 for exactly that one IDLE cycle.
REQ-026 Read completion SHALL latch avm_readdata into x_rdata; x_rdata holds until next completion of that channel; d_rdata unchanged on writes.
REQ-027 Minimum latency: req in IDLE at cycle 0, waitrequest=0 at cycle 1 -> ack at cycle 2.
REQ-028 Wait counter (ceil(log2(TIMEOUT+1)) bits) SHALL clear on grant and increment each BUS_x cycle with waitrequest=1.
REQ-029 TIMEOUT!=0 and counter reaches TIMEOUT with waitrequest still 1: abort -> IDLE, ack that channel, x_rdata=all ones (reads), timeout_err=1 until reset.
REQ-030 Instruction channel waits at most one data access when both requests are pending.
REQ-031 Request dropped mid-access: access still completes on bus; ack still pulses.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, counter=0, avm_read=avm_write=0, i_ack=d_ack=0, timeout_err=0, i_rdata=d_rdata=0, capture registers=0.
REQ-033 Reset mid-access SHALL abort immediately with no ack; bus signals drop without waiting for a clock edge.

Verification
REQ-034 Fetch, zero-wait: i_req=1, i_addr=0xBFC00000, readdata=0x24020005 -> avm_read in cycle 1, i_ack and i_rdata=0x24020005 in cycle 2, stall=0 in cycle 2.
REQ-035 Simultaneous i_req and d_req (write 0x10 <= 0xDEADBEEF, be=4'b0011) -> data access first with byteenable=0011, then fetch; i_ack no earlier than 3 cycles after d_ack.
REQ-036 Read with waitrequest=1 for 4 cycles -> avm_address/avm_read stable all 5 cycles, d_ack exactly one cycle after waitrequest falls.
REQ-037 TIMEOUT=8, waitrequest stuck high -> abort after 8 wait cycles, d_ack=1, d_rdata=0xFFFFFFFF, timeout_err=1 held until reset.
REQ-038 reset pulsed during BUS_D with waitrequest=1 -> avm_write=0 before next edge, no d_ack, FSM IDLE, held d_req re-granted after reset release.
